// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared word types, size/state enums and lane-mask helper for the LSU
package definitions_pkg;

   typedef logic        [31:0] word_ut;
   typedef logic signed [31:0] word_st;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC0 = 2'b01,
      ACC1 = 2'b10,
      RESP = 2'b11
   } lsu_state_e;

   // Lanes [3:0] belong to the first word, [7:4] spill into the next word.
   function automatic logic [7:0] lane_mask(input mem_size_e size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         SIZE_BYTE: base = 8'h01;
         SIZE_HALF: base = 8'h03;
         SIZE_WORD: base = 8'h0F;
         default:   base = 8'h00;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of a right-justified load value
module load_extend
   import definitions_pkg::*;
(
   input  word_ut    raw_i,
   input  mem_size_e size_i,
   input  logic      unsigned_i,
   output word_ut    data_o
);

   always_comb begin
      data_o = raw_i;
      case (size_i)
         SIZE_BYTE: data_o = unsigned_i ? {24'h0, raw_i[7:0]}
                                        : {{24{raw_i[7]}}, raw_i[7:0]};
         SIZE_HALF: data_o = unsigned_i ? {16'h0, raw_i[15:0]}
                                        : {{16{raw_i[15]}}, raw_i[15:0]};
         default:   data_o = raw_i;
      endcase
   end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store aligner splitting misaligned accesses into two word accesses
module lsu_align
   import definitions_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i
);

   lsu_state_e state_q, state_d;
   logic       we_q, uns_q, err_q;
   mem_size_e  size_q;
   word_ut     addr_q, wdata_q, rd0_q, rd1_q;

   logic [7:0]  mask;
   logic [63:0] sw;
   word_ut      raw, ext;
   word_ut      word_addr;

   assign mask      = lane_mask(size_q, addr_q[1:0]);
   assign sw        = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
   assign raw       = 32'({rd1_q, rd0_q} >> {addr_q[1:0], 3'b000});
   assign word_addr = {addr_q[31:2], 2'b00};

   load_extend u_load_extend (
      .raw_i      (raw),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SIZE_BYTE;
         addr_q  <= '0;
         wdata_q <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid_i) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            err_q   <= (req_size_i == SIZE_ILL);
            size_q  <= mem_size_e'(req_size_i);
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd0_q   <= '0;
            rd1_q   <= '0;
         end
         if (state_q == ACC0) rd0_q <= mem_rd_i;
         if (state_q == ACC1) rd1_q <= mem_rd_i;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = 4'b0000;
      mem_addr_o   = word_addr;
      mem_wd_o     = '0;
      resp_valid_o = 1'b0;
      resp_err_o   = 1'b0;
      resp_rdata_o = '0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = (req_size_i == SIZE_ILL) ? RESP : ACC0;
         end
         ACC0: begin
            mem_we_o = we_q;
            mem_be_o = mask[3:0];
            mem_wd_o = sw[31:0];
            state_d  = (mask[7:4] != 4'b0000) ? ACC1 : RESP;
         end
         ACC1: begin
            mem_we_o   = we_q;
            mem_be_o   = mask[7:4];
            mem_addr_o = word_addr + 32'd4;
            mem_wd_o   = sw[63:32];
            state_d    = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            resp_rdata_o = (we_q || err_q) ? '0 : ext;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - scoreboard testbench for lsu_align
module tb_lsu_align;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] wm;
      logic        we;
   } acc_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   acc_t acc_q[$];
   rsp_t rsp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] ram [0:255];
   logic [7:0]  shadow [0:1023];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   lsu_align dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_size_i     (req_size),
      .req_unsigned_i (req_unsigned),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .resp_valid_o   (resp_valid),
      .resp_rdata_o   (resp_rdata),
      .resp_err_o     (resp_err),
      .mem_we_o       (mem_we),
      .mem_be_o       (mem_be),
      .mem_addr_o     (mem_addr),
      .mem_wd_o       (mem_wd),
      .mem_rd_i       (mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd = ram[mem_addr[9:2]];

   always @(posedge clk) begin
      if (pre_we) ram[pre_idx] <= pre_data;
      else if (mem_we)
         for (int l = 0; l < 4; l++)
            if (mem_be[l]) ram[mem_addr[9:2]][8*l +: 8] <= mem_wd[8*l +: 8];
   end

   function automatic void push_acc(input logic [31:0] addr, input logic [3:0] be,
                                    input logic [31:0] wd, input logic [31:0] wm, input logic we);
      acc_q.push_back('{addr: addr, be: be, wd: wd, wm: wm, we: we});
   endfunction

   function automatic void push_rsp(input logic [31:0] rdata, input logic err);
      rsp_q.push_back('{rdata: rdata, err: err});
   endfunction

   // Pop and compare whatever the DUT presents on the RAM and response ports this cycle.
   task automatic sample();
      acc_t a;
      rsp_t r;
      if (mem_we || mem_be != 4'b0000) begin
         n_checks++;
         if (acc_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_access: addr=%h be=%b we=%b, required no access", mem_addr, mem_be, mem_we);
         end else begin
            a = acc_q.pop_front();
            if (mem_addr !== a.addr || mem_be !== a.be || mem_we !== a.we ||
                (((mem_wd ^ a.wd) & a.wm) !== 32'h0)) begin
               n_fail++;
               $display("FAIL mem_access: addr=%h be=%b we=%b wd=%h, required addr=%h be=%b we=%b wd=%h (mask %h)",
                        mem_addr, mem_be, mem_we, mem_wd, a.addr, a.be, a.we, a.wd, a.wm);
            end
         end
      end
      if (resp_valid) begin
         n_checks++;
         if (rsp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_resp: rdata=%h err=%b, required no response", resp_rdata, resp_err);
         end else begin
            r = rsp_q.pop_front();
            if (resp_rdata !== r.rdata || resp_err !== r.err) begin
               n_fail++;
               $display("FAIL response: rdata=%h err=%b, required rdata=%h err=%b", resp_rdata, resp_err, r.rdata, r.err);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = data;
      for (int b = 0; b < 4; b++) shadow[{idx, 2'(b)}] = data[8*b +: 8];
      tick();
      pre_we = 1'b0;
   endtask

   // lat counts cycles inclusive of the accept cycle, so the accept cycle is 1.
   task automatic send(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic rdy_idle, output logic rdy_busy);
      tick();
      rdy_idle     = req_ready;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      rdy_busy     = 1'b0;
      lat          = 1;
      do begin
         tick();
         lat++;
         req_we       = 1'($urandom);
         req_size     = 2'($urandom);
         req_unsigned = 1'($urandom);
         req_addr     = $urandom;
         req_wdata    = $urandom;
         if (req_ready) rdy_busy = 1'b1;
      end while (!resp_valid && lat < 12);
      req_valid = 1'b0;
   endtask

   task automatic check_txn(input string name, input int lat, input int exp_lat,
                            input logic rdy_idle, input logic rdy_busy);
      n_checks++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (rdy_idle !== 1'b1 || rdy_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready: idle=%b busy=%b, required idle=1 busy=0", name, rdy_idle, rdy_busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
          resp_rdata !== 32'h0 || mem_we !== 1'b0 || mem_be !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b rv=%b err=%b rdata=%h we=%b be=%b, required 1 0 0 0 0 0",
                  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_be);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_store_aligned();
      int lat; logic ri, rb;
      push_acc(32'h100, 4'b1111, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
      push_rsp(32'h0, 1'b0);
      send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, ri, rb);
      check_txn("sw_aligned", lat, 3, ri, rb);
   endtask

   task automatic test_store_byte();
      int lat; logic ri, rb;
      push_acc(32'h100, 4'b1000, 32'hA5000000, 32'hFFFFFFFF, 1'b1);
      push_rsp(32'h0, 1'b0);
      send(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, lat, ri, rb);
      check_txn("sb_lane3", lat, 3, ri, rb);
   endtask

   task automatic test_load_half();
      int lat; logic ri, rb;
      preload(8'h40, 32'h80FF0000);
      push_acc(32'h100, 4'b1100, 32'h0, 32'h0, 1'b0);
      push_rsp(32'hFFFF80FF, 1'b0);
      send(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, ri, rb);
      check_txn("lh", lat, 3, ri, rb);
      push_acc(32'h100, 4'b1100, 32'h0, 32'h0, 1'b0);
      push_rsp(32'h000080FF, 1'b0);
      send(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, ri, rb);
      check_txn("lhu", lat, 3, ri, rb);
   endtask

   task automatic test_load_cross();
      int lat; logic ri, rb;
      preload(8'h40, 32'h11223344);
      preload(8'h41, 32'hAABBCCDD);
      push_acc(32'h100, 4'b1000, 32'h0, 32'h0, 1'b0);
      push_acc(32'h104, 4'b0111, 32'h0, 32'h0, 1'b0);
      push_rsp(32'hBBCCDD11, 1'b0);
      send(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, lat, ri, rb);
      check_txn("lw_cross", lat, 4, ri, rb);
   endtask

   task automatic test_illegal();
      int lat; logic ri, rb;
      push_rsp(32'h0, 1'b1);
      send(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, lat, ri, rb);
      check_txn("illegal", lat, 2, ri, rb);
   endtask

   // Back-to-back random traffic against a byte-addressed shadow memory.
   task automatic test_back_to_back();
      int lat, n, exp_lat; logic ri, rb;
      logic we, uns; logic [1:0] size;
      logic [31:0] addr, wdata, base, a, v;
      logic [3:0] be0, be1;
      logic [31:0] wd0, wd1, wm0, wm1;
      for (int k = 0; k < 40; k++) begin
         we    = 1'($urandom);
         uns   = 1'($urandom);
         size  = 2'($urandom_range(0, 2));
         addr  = 32'h300 + 32'($urandom_range(0, 32'hEF));
         wdata = $urandom;
         n     = 1 << size;
         base  = addr & ~32'h3;
         be0 = '0; be1 = '0; wd0 = '0; wd1 = '0; wm0 = '0; wm1 = '0; v = '0;
         for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if ((a & ~32'h3) == base) begin
               be0[a[1:0]] = 1'b1;
               wd0[8*a[1:0] +: 8] = wdata[8*i +: 8];
               wm0[8*a[1:0] +: 8] = 8'hFF;
            end else begin
               be1[a[1:0]] = 1'b1;
               wd1[8*a[1:0] +: 8] = wdata[8*i +: 8];
               wm1[8*a[1:0] +: 8] = 8'hFF;
            end
            if (we) shadow[a[9:0]] = wdata[8*i +: 8];
            else    v[8*i +: 8]    = shadow[a[9:0]];
         end
         if (!we && !uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
         push_acc(base, be0, wd0, we ? wm0 : 32'h0, we);
         if (be1 != 4'b0000) push_acc(base + 32'd4, be1, wd1, we ? wm1 : 32'h0, we);
         push_rsp(we ? 32'h0 : v, 1'b0);
         exp_lat = (be1 != 4'b0000) ? 4 : 3;
         send(we, size, uns, addr, wdata, lat, ri, rb);
         check_txn("random", lat, exp_lat, ri, rb);
      end
   endtask

   task automatic test_reset_acc1();
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_acc1_ready_before: got %b, required 1", req_ready);
      end
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr  = 32'h0FE; req_wdata = 32'h12345678;
      push_acc(32'h0FC, 4'b1100, 32'h56780000, 32'hFFFFFFFF, 1'b1);
      push_acc(32'h100, 4'b0011, 32'h00001234, 32'hFFFFFFFF, 1'b1);
      tick();
      req_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || mem_be !== 4'b0000 || resp_valid !== 1'b0 ||
          resp_err !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_acc1_async_clear: we=%b be=%b rv=%b err=%b rdata=%h ready=%b, required 0 0 0 0 0 1",
                  mem_we, mem_be, resp_valid, resp_err, resp_rdata, req_ready);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_acc1_after_release: ready=%b rv=%b, required ready=1 rv=0", req_ready, resp_valid);
      end
      n_checks++;
      if (ram[8'h3F][31:16] !== 16'h5678 || ram[8'h40] !== 32'h11223344) begin
         n_fail++;
         $display("FAIL rst_acc1_ram: word0=%h word1=%h, required word0[31:16]=5678 word1=11223344",
                  ram[8'h3F], ram[8'h40]);
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
      test_reset();
      for (int w = 0; w < 256; w++) preload(8'(w), $urandom);
      test_store_aligned();
      test_store_byte();
      test_load_half();
      test_load_cross();
      test_illegal();
      test_back_to_back();
      test_reset_acc1();
      n_checks++;
      if (acc_q.size() != 0 || rsp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drained: %0d accesses and %0d responses outstanding, required 0 and 0",
                  acc_q.size(), rsp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameters: none; data width is 32 bits, and all data-word types (word_ut/word_st) come from definitions_pkg.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  in  1  core presents a load/store request.
REQ-005 req_ready_o  out  1  the block accepts a request this cycle.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  mem_size_e: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned_i  in  1  zero-extend load result (LBU/LHU).
REQ-009 req_addr_i  in  32  byte address, any alignment.
REQ-010 req_wdata_i  in  32  store data, right-justified.
REQ-011 resp_valid_o  out  1  one-cycle pulse that completes a request.
REQ-012 resp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err_o  out  1  qualifies resp_valid_o; set when size is illegal.
REQ-014 mem_we_o  out  1  data RAM write enable.
REQ-015 mem_be_o  out  4  data RAM byte enables, one bit per byte lane.
REQ-016 mem_addr_o  out  32  word-aligned RAM address, bits [1:0] = 00.
REQ-017 mem_wd_o  out  32  lane-positioned RAM write data.
REQ-018 mem_rd_i  in  32  RAM read data, combinational on mem_addr_o.

Function
REQ-019 FSM states are IDLE, ACC0, ACC1 and RESP (lsu_state_e).
REQ-020 IDLE: req_ready_o=1; when req_valid_i=1, register the request and go to ACC0, or go to RESP with the error flag set if size=11.
REQ-021 req_ready_o is 0 in every state other than IDLE.
REQ-022 Byte offset off=addr[1:0]; 8-bit lane mask m = (size byte:0x01, half:0x03, word:0x0F) << off.
REQ-023 Shifted write data: a 64-bit value sw = wdata << 8*off.
REQ-024 ACC0: mem_addr_o={addr[31:2],00}, mem_be_o=m[3:0], mem_wd_o=sw[31:0], mem_we_o=we; capture mem_rd_i into rd0.
REQ-025 ACC0 transition: go to ACC1 if m[7:4]!=0 (crossing), else go to RESP.
REQ-026 ACC1: mem_addr_o=word address+4 (wraps at 2^32), mem_be_o=m[7:4], mem_wd_o=sw[63:32], mem_we_o=we; capture rd1; go to RESP.
REQ-027 RESP: resp_valid_o=1 for exactly one cycle; go to IDLE.
REQ-028 Load result: raw = {rd1,rd0} >> 8*off; byte/half are sign- or zero-extended per req_unsigned_i; word is passed through.
REQ-029 In IDLE and RESP: mem_we_o=0 and mem_be_o=0.
REQ-030 Latency: 3 cycles from accept to resp_valid_o when aligned or non-crossing; 4 cycles when crossing; the next accept is possible in the cycle after RESP.
REQ-031 Illegal size produces no RAM access, and resp_valid_o is asserted with resp_err_o=1 the cycle after accept.
REQ-032 Request inputs are ignored outside IDLE; the registered copy alone drives ACC0/ACC1.

Reset
REQ-033 While rst_ni=0: state=IDLE; all registers cleared; mem_we_o=0, mem_be_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0 immediately, without waiting for a clock edge.
REQ-034 Reset asserted in ACC1 abandons the second half; a half-written store is not completed or rolled back.

Structure
REQ-035 mem_size_e and lsu_state_e are defined in definitions_pkg.
REQ-036 Load sign/zero extension is implemented in one combinational sub-module, load_extend.

Verification
REQ-037 Aligned SW to 0x100 with data 0xDEADBEEF -> one ACC0 with be=1111, addr=0x100, wd=0xDEADBEEF; resp_valid_o 3 cycles after accept.
REQ-038 SB to 0x103 with data 0x000000A5 -> be=1000, wd=0xA5000000, no ACC1.
REQ-039 LH from 0x102 with RAM word 0x80FF0000 -> rdata=0xFFFF80FF; LHU from the same address -> rdata=0x000080FF.
REQ-040 LW from 0x103 (crossing) with RAM words 0x11223344 and 0xAABBCCDD -> ACC0 at 0x100 with be=1000, then ACC1 at 0x104 with be=0111; rdata=0xBBCCDD11; latency 4.
REQ-041 Request with size=11 at 0x200 -> no mem_be_o activity; resp_valid_o=1 and resp_err_o=1 the cycle after accept.
REQ-042 Crossing SW to 0x0FE with rst_ni dropped during ACC1 -> outputs clear without a clock edge, the block returns to IDLE, and req_ready_o=1 after reset is released.
